// File: rtl/frame_strobe_sequencer.sv
// rtl/frame_strobe_sequencer.sv - one-hot frame strobe sequencer with LOAD/STROBE/HOLD timing
module frame_strobe_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int StrobeCycles    = 1
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_frame_idx,
    input  logic [FrameBitsPerRow-1:0] in_data,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic                       busy,
    output logic                       err,
    input  logic                       err_clr,
    output logic [15:0]                frames_written
);
    typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_t;

    localparam logic [5:0] IdxLimit   = 6'(MaxFramesPerCol);
    localparam logic [3:0] StrobeLoad = 4'(StrobeCycles);

    state_t                     state, state_next;
    logic [4:0]                 idx_q;
    logic [3:0]                 strobe_cnt;
    logic [MaxFramesPerCol-1:0] strobe_onehot;
    logic                       accept;
    logic                       idx_ok;
    logic                       strobe_last;

    assign in_ready    = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = in_valid && in_ready;
    assign idx_ok      = ({1'b0, in_frame_idx} < IdxLimit);
    assign strobe_last = (strobe_cnt <= 4'd1);

    always_comb begin
        strobe_onehot = '0;
        for (int i = 0; i < MaxFramesPerCol; i++) begin
            strobe_onehot[i] = (idx_q == 5'(i));
        end
    end

    // Out-of-range commands are consumed in IDLE and only raise err.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && idx_ok) state_next = LOAD;
            LOAD:    state_next = STROBE;
            STROBE:  if (strobe_last) state_next = HOLD;
            HOLD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            FrameData      <= '0;
            FrameStrobe    <= '0;
            idx_q          <= '0;
            strobe_cnt     <= '0;
            frames_written <= '0;
        end else begin
            if (accept && idx_ok) begin
                FrameData <= in_data;
                idx_q     <= in_frame_idx;
            end
            if (state == LOAD) begin
                FrameStrobe <= strobe_onehot;
                strobe_cnt  <= StrobeLoad;
            end else if (state == STROBE) begin
                if (strobe_last) begin
                    FrameStrobe    <= '0;
                    strobe_cnt     <= '0;
                    frames_written <= frames_written + 16'd1;
                end else begin
                    strobe_cnt <= strobe_cnt - 4'd1;
                end
            end
        end
    end

    // A set on the same edge as a clear takes priority.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (accept && !idx_ok) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// tb/tb_frame_strobe_sequencer.sv - randomized self-checking bench for frame_strobe_sequencer
module tb_frame_strobe_sequencer;
    localparam int S    = 4;
    localparam int MAXF = 20;
    localparam int W    = 32;

    logic            CLK = 1'b0;
    logic            resetn;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_frame_idx;
    logic [W-1:0]    in_data;
    logic [W-1:0]    FrameData;
    logic [MAXF-1:0] FrameStrobe;
    logic            busy;
    logic            err;
    logic            err_clr;
    logic [15:0]     frames_written;

    frame_strobe_sequencer #(
        .MaxFramesPerCol(MAXF),
        .FrameBitsPerRow(W),
        .StrobeCycles   (S)
    ) dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_frame_idx  (in_frame_idx),
        .in_data       (in_data),
        .FrameData     (FrameData),
        .FrameStrobe   (FrameStrobe),
        .busy          (busy),
        .err           (err),
        .err_clr       (err_clr),
        .frames_written(frames_written)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a timeline of when each accepted command's effects appear.
    int          cyc, ready_at, s_start, s_end, cnt_due;
    logic [4:0]  s_idx;
    logic [W-1:0] m_data;
    logic        m_err;
    logic [15:0] m_count;

    task automatic m_reset();
        cyc = 0; ready_at = 0; s_start = 1; s_end = 0; cnt_due = -1;
        s_idx = '0; m_data = '0; m_err = 1'b0; m_count = '0;
    endtask

    task automatic cycle(input logic v, input logic [4:0] idx, input logic [W-1:0] d,
                         input logic clr, output logic acc);
        logic [MAXF-1:0] exp_strobe;
        logic            m_ready;
        if (cyc == cnt_due) m_count = m_count + 16'd1;
        m_ready    = (cyc >= ready_at);
        exp_strobe = (cyc >= s_start && cyc <= s_end) ? (MAXF'(1) << s_idx) : '0;
        check("in_ready", 64'(in_ready), 64'(m_ready));
        check("busy", 64'(busy), 64'(!m_ready));
        check("FrameData", 64'(FrameData), 64'(m_data));
        check("FrameStrobe", 64'(FrameStrobe), 64'(exp_strobe));
        check("err", 64'(err), 64'(m_err));
        check("frames_written", 64'(frames_written), 64'(m_count));
        in_valid = v; in_frame_idx = idx; in_data = d; err_clr = clr;
        acc = v && m_ready;
        if (acc && idx < MAXF) begin
            m_data   = d;
            s_idx    = idx;
            s_start  = cyc + 2;
            s_end    = cyc + 1 + S;
            cnt_due  = cyc + 2 + S;
            ready_at = cyc + 3 + S;
        end
        if (acc && idx >= MAXF) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        cyc++;
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input logic clr);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, '0, clr, acc);
    endtask

    task automatic send(input logic [4:0] idx, input logic [W-1:0] d, input logic clr);
        logic acc;
        int   guard;
        acc = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            cycle(1'b1, idx, d, clr, acc);
            guard++;
        end
        if (!acc) check("accept_timeout", 64'(acc), 64'(1));
    endtask

    initial begin
        resetn = 1'b0; in_valid = 1'b0; in_frame_idx = '0; in_data = '0; err_clr = 1'b0;
        m_reset();
        repeat (2) @(negedge CLK);
        check("rst_strobe", 64'(FrameStrobe), 64'(0));
        check("rst_data", 64'(FrameData), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_count", 64'(frames_written), 64'(0));
        resetn = 1'b1;
        @(negedge CLK);
        m_reset();

        send(5'd3, 32'hA5A5A5A5, 1'b0);
        idle(6, 1'b0);
        send(5'd19, 32'h0BAD_F00D, 1'b0);
        idle(8, 1'b0);
        send(5'd20, 32'hDEAD_BEEF, 1'b0);
        idle(2, 1'b0);
        send(5'd25, 32'h1111_2222, 1'b1);
        idle(2, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        for (int i = 0; i < MAXF; i++) send(5'(i), $urandom, 1'b0);
        idle(S + 4, 1'b0);

        for (int n = 0; n < 150; n++) begin
            idle(int'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0));
            send(5'($urandom_range(0, 24)), $urandom, 1'($urandom_range(0, 7) == 0));
        end
        idle(S + 4, 1'b1);

        send(5'd5, 32'h1234_5678, 1'b0);
        idle(2, 1'b0);
        check("strobe_before_rst", 64'(FrameStrobe), 64'(MAXF'(1) << 5));
        resetn = 1'b0;
        #1;
        check("async_rst_strobe", 64'(FrameStrobe), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_count", 64'(frames_written), 64'(0));
        @(negedge CLK);
        resetn = 1'b1;
        @(negedge CLK);
        m_reset();
        idle(1, 1'b0);

        force dut.frames_written = 16'hFFFF;
        #1;
        release dut.frames_written;
        m_count = 16'hFFFF;
        idle(1, 1'b0);
        send(5'd7, 32'hCAFE_0007, 1'b0);
        idle(S + 3, 1'b0);
        check("count_wrap", 64'(frames_written), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_strobe_sequencer.md
FRAME_STROBE_SEQUENCER -- requirements
Module: frame_strobe_sequencer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20: number of frame strobes per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32: width of the frame data word.
REQ-003 SHALL have parameter StrobeCycles, default 1, legal 1..15: cycles each strobe pulse is held.
REQ-004 SHALL have port CLK, input, 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1: frame write command valid.
REQ-007 SHALL have port in_ready, output, 1: sequencer accepts a command this cycle.
REQ-008 SHALL have port in_frame_idx, input, 5: target strobe index.
REQ-009 SHALL have port in_data, input, FrameBitsPerRow: frame word to write.
REQ-010 SHALL have port FrameData, output, FrameBitsPerRow: registered frame word driven to the column.
REQ-011 SHALL have port FrameStrobe, output, MaxFramesPerCol: registered one-hot strobe bus to the column.
REQ-012 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-013 SHALL have port err, output, 1: sticky out-of-range index flag.
REQ-014 SHALL have port err_clr, input, 1: clears err.
REQ-015 SHALL have port frames_written, output, 16: count of completed strobe pulses.

Function
REQ-016 SHALL implement states IDLE, LOAD, STROBE, HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE; a command is accepted on a cycle where in_valid and in_ready are both 1.
REQ-018 On accepting a valid command at edge T, the block SHALL register in_data into FrameData and the index internally, and SHALL enter LOAD with FrameStrobe all-zero.
REQ-019 From LOAD, the block SHALL enter STROBE on the next edge, driving FrameStrobe[idx]=1 (all other bits 0) for exactly StrobeCycles cycles, using a 4-bit down-counter.
REQ-020 After the last STROBE cycle, the block SHALL enter HOLD for one cycle with FrameStrobe all-zero and FrameData unchanged, then return to IDLE.
REQ-021 The cycle from acceptance to the next possible acceptance SHALL be 3+StrobeCycles cycles.
REQ-022 FrameData SHALL stay stable from LOAD through HOLD and SHALL retain its last value in IDLE.
REQ-023 A command with in_frame_idx >= MaxFramesPerCol SHALL still be accepted, SHALL NOT change FrameData or FrameStrobe, SHALL set err on the next edge, and the block SHALL remain in IDLE.
REQ-024 err SHALL clear on an edge where err_clr=1; if a set and a clear occur on the same edge, set SHALL win.
REQ-025 frames_written SHALL increment by 1 on the edge leaving STROBE, wrapping from 0xFFFF to 0.
REQ-026 FrameStrobe SHALL never have more than one bit high, and SHALL never be high while FrameData is changing.
REQ-027 in_valid in any state other than IDLE SHALL be ignored and the command SHALL not be lost; the requester holds it until in_ready.

Reset
REQ-028 When resetn=0, the block SHALL asynchronously force IDLE, FrameStrobe=0, FrameData=0, err=0, frames_written=0, busy=0, and set the strobe counter to 0.
REQ-029 Assertion of resetn mid-STROBE SHALL drop FrameStrobe to 0 immediately, without waiting for a clock edge.
REQ-030 After resetn deasserts, in_ready SHALL be 1 on the first clock edge.

Verification
REQ-031 StrobeCycles=1, accept idx=3, data=0xA5A5A5A5 -> FrameData=0xA5A5A5A5 at T+1; FrameStrobe=0x00008 for one cycle at T+2; in_ready=1 again at T+4; frames_written=1.
REQ-032 StrobeCycles=4, idx=19 -> bit 19 high for exactly 4 cycles; next acceptance no earlier than T+7.
REQ-033 idx=20 -> err=1 next cycle; FrameStrobe stays 0; FrameData unchanged; then err_clr=1 together with a new idx=25 -> err remains 1.
REQ-034 resetn pulled low during the second STROBE cycle -> FrameStrobe=0 and busy=0 asynchronously; frames_written is not incremented.
REQ-035 Back-to-back commands with in_valid held high (idx 0..19) -> 20 one-hot pulses in order; frames_written=20; no overlap between pulses; FrameData is constant during each pulse.
REQ-036 Preload frames_written=0xFFFF via 65535 writes (or force), then one more write -> 0x0000.
